// File: rtl/ble_fifo_pkg.sv
// Shared constants and pointer-code helpers for the BLE PHY async FIFO.
// Both the read- and write-pointer blocks import this package.
package ble_fifo_pkg;

    localparam int BLE_FIFO_ADDR_WIDTH = 4;
    localparam int BLE_DATA_SIZE_W     = 17;

    typedef logic [BLE_FIFO_ADDR_WIDTH:0] ble_ptr_t;

    function automatic ble_ptr_t bin2gray(input ble_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ble_ptr_t gray2bin(input ble_ptr_t gray);
        ble_ptr_t bin;
        bin[BLE_FIFO_ADDR_WIDTH] = gray[BLE_FIFO_ADDR_WIDTH];
        for (int i = BLE_FIFO_ADDR_WIDTH - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_ble.sv
// Two-flop synchroniser for Gray pointers crossing between FIFO clock domains.
module fifo_sync_ble #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    // Two-stage metastability filter, cleared to zero on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1 <= {WIDTH{1'b0}};
            q      <= {WIDTH{1'b0}};
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/fifo_read_pointer_ble.sv
// Read-side pointer, EMPTY flag, frame-end interrupt and underflow logic
// of the BLE PHY asynchronous FIFO.
module fifo_read_pointer_ble
    import ble_fifo_pkg::*;
(
    input  logic                         R_CLK,
    input  logic                         R_rst,
    input  logic                         R_inc,
    input  logic [BLE_FIFO_ADDR_WIDTH:0] Wptr_gray,
    input  logic [BLE_DATA_SIZE_W-1:0]   data_size,
    input  logic [BLE_DATA_SIZE_W-1:0]   R_Addr_bits,
    output logic                         EMPTY_VALUE,
    output logic [BLE_FIFO_ADDR_WIDTH:0] R_ptr,
    output logic [BLE_FIFO_ADDR_WIDTH-1:0] R_Addr,
    output logic                         R_valid,
    output logic                         rx_irq,
    output logic                         R_underflow
);

    localparam int AW = BLE_FIFO_ADDR_WIDTH;

    logic [AW:0] bin_ptr;
    logic [AW:0] bin_next;
    logic [AW:0] rq2_wptr;
    logic        accept;
    logic        frame_end;

    fifo_sync_ble #(.WIDTH(AW + 1)) u_wptr_sync (
        .clk (R_CLK),
        .rst (R_rst),
        .d   (Wptr_gray),
        .q   (rq2_wptr)
    );

    assign EMPTY_VALUE = (R_ptr == rq2_wptr);
    assign accept      = R_inc & ~EMPTY_VALUE;
    assign frame_end   = (R_Addr_bits >= data_size);
    assign R_Addr      = bin_ptr[AW-1:0];

    // Next binary pointer: a frame end jumps to the start of the other lap, as the writer does
    always_comb begin
        bin_next = bin_ptr;
        if (frame_end) begin
            bin_next = {~bin_ptr[AW], {AW{1'b0}}};
        end else begin
            bin_next = bin_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer state, Gray export and status outputs
    always_ff @(posedge R_CLK or posedge R_rst) begin
        if (R_rst) begin
            bin_ptr     <= {(AW + 1){1'b0}};
            R_ptr       <= {(AW + 1){1'b0}};
            R_valid     <= 1'b0;
            rx_irq      <= 1'b0;
            R_underflow <= 1'b0;
        end else begin
            if (accept) begin
                bin_ptr <= bin_next;
                R_ptr   <= bin2gray(bin_next);
            end
            R_valid <= accept;
            rx_irq  <= accept & frame_end;
            if (R_inc & EMPTY_VALUE) begin
                R_underflow <= 1'b1;
            end
        end
    end

endmodule
